// File: rtl/ram_pkg.sv
// Shared types and constants for the simple-dual-port byte-enable RAM.
package ram_pkg;

    // Power-up sequencing: CLEAR walks every word to zero, DONE opens the user ports.
    typedef enum logic {
        CLEAR = 1'b0,
        DONE  = 1'b1
    } ram_state_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/ram_sdp_be_if.sv
// Bus bundle for ram_sdp_be: one write port, one read port and status.
//
// Handshake: a request (wr_en or rd_en) is accepted on any rising clk edge
// where ready is high; there is no backpressure once ready is high, and
// requests presented while ready is low are dropped. Every accepted read
// produces exactly one rd_valid pulse after the read latency.
interface ram_sdp_be_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16000
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BE_W   = DATA_W / 8;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ready;
    logic              oob_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, ready, oob_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, ready, oob_err
    );

endinterface

// File: rtl/ram_sdp_be_core.sv
// Bare storage array: byte-enable write, registered read, no reset and no
// address checking, so synthesis maps it straight onto block RAM.
module ram_sdp_be_core
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16000,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   wbe_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write: only lanes with their enable set are touched.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wbe_i[b]) begin
                    mem[waddr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Synchronous read returning the pre-write contents; the wrapper merges bypass data.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM wrapper: power-up clear FSM, write-first forwarding,
// out-of-range protection and read-valid strobe around ram_sdp_be_core.
// Optional build macro RAM_OUTREG_EN adds an output register after the
// forwarding merge (read latency 2 instead of 1).
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 16000,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_sdp_be_if.slave  bus,
    output ram_state_t   dbg_state_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BE_W   = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    ram_state_t        state_q;
    logic [ADDR_W-1:0] clr_addr_q;
    logic              ready_q;
    logic              oob_q;

    logic              wr_in;
    logic              rd_in;
    logic              wr_ok;
    logic              rd_acc;

    logic              core_we;
    logic [ADDR_W-1:0] core_waddr;
    logic [DATA_W-1:0] core_wdata;
    logic [BE_W-1:0]   core_wbe;
    logic [DATA_W-1:0] core_rdata;

    logic              rd_v1_q;
    logic              rd_zero_q;
    logic              fwd_hit_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [BE_W-1:0]   fwd_be_q;
    logic [DATA_W-1:0] rd_data_d;

    assign wr_in  = {1'b0, bus.wr_addr} < DEPTH_V;
    assign rd_in  = {1'b0, bus.rd_addr} < DEPTH_V;
    assign wr_ok  = ready_q && bus.wr_en && wr_in;
    assign rd_acc = ready_q && bus.rd_en;

    // Clear sequencer: one zeroed word per cycle, then park in DONE until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : DONE;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_addr_q == LAST_A) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= DONE;
                end
            endcase
        end
    end

    // Core write port: the clear walker owns it until DONE, then the user port.
    always_comb begin
        core_we    = wr_ok;
        core_waddr = bus.wr_addr;
        core_wdata = bus.wr_data;
        core_wbe   = bus.wr_be;
        if (state_q == CLEAR) begin
            core_we    = 1'b1;
            core_waddr = clr_addr_q;
            core_wdata = '0;
            core_wbe   = '1;
        end
    end

    ram_sdp_be_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk_i   (clk),
        .we_i    (core_we),
        .waddr_i (core_waddr),
        .wdata_i (core_wdata),
        .wbe_i   (core_wbe),
        .re_i    (rd_acc && rd_in),
        .raddr_i (bus.rd_addr),
        .rdata_o (core_rdata)
    );

    // Read side-band: bypass info and zero-forcing captured with each accepted read,
    // held otherwise so rd_data stays stable. rd_zero_q starts set so rd_data is 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q    <= 1'b0;
            rd_zero_q  <= 1'b1;
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            fwd_be_q   <= '0;
            oob_q      <= 1'b0;
        end else begin
            rd_v1_q <= rd_acc;
            if (rd_acc) begin
                rd_zero_q  <= !rd_in;
                fwd_hit_q  <= wr_ok && (bus.wr_addr == bus.rd_addr);
                fwd_data_q <= bus.wr_data;
                fwd_be_q   <= bus.wr_be;
            end
            if (ready_q && ((bus.wr_en && !wr_in) || (bus.rd_en && !rd_in))) begin
                oob_q <= 1'b1;
            end
        end
    end

    // Write-first merge: bytes written in the read cycle override the old RAM word.
    always_comb begin
        rd_data_d = core_rdata;
        for (int b = 0; b < BE_W; b++) begin
            if (fwd_hit_q && fwd_be_q[b]) begin
                rd_data_d[b*BYTE_W +: BYTE_W] = fwd_data_q[b*BYTE_W +: BYTE_W];
            end
        end
        if (rd_zero_q) begin
            rd_data_d = '0;
        end
    end

`ifdef RAM_OUTREG_EN
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Extra output stage after the merge; valid is delayed alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_v1_q;
            if (rd_v1_q) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`else
    assign bus.rd_data  = rd_data_d;
    assign bus.rd_valid = rd_v1_q;
`endif

    assign bus.ready   = ready_q;
    assign bus.oob_err = oob_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be (DATA_W=32, DEPTH=16000, CLEAR_ON_RESET=1).
module tb_ram_sdp_be;
  import ram_pkg::*;

`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  ram_state_t dbg_state;

  ram_sdp_be_if #(.DATA_W(32), .DEPTH(16000)) bus ();

  ram_sdp_be #(
    .DATA_W(32),
    .DEPTH(16000),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
  endtask

  task automatic issue(input logic we, input logic [13:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [13:0] ra);
    @(negedge clk);
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.wr_be = be;
    bus.rd_en = re; bus.rd_addr = ra;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // Waits for the read issued by the preceding issue() and checks data plus pulse shape.
  task automatic collect_read(input logic [31:0] exp, input string tag);
    for (int i = 1; i < LAT; i++) begin
      check_eq({tag, "_early"}, {31'd0, bus.rd_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check_eq({tag, "_valid"}, {31'd0, bus.rd_valid}, 32'd1);
    check_eq({tag, "_data"}, bus.rd_data, exp);
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, {31'd0, bus.rd_valid}, 32'd0);
    check_eq({tag, "_hold"}, bus.rd_data, exp);
  endtask

  task automatic do_read(input logic [13:0] a, input logic [31:0] exp, input string tag);
    issue(1'b0, 14'd0, 32'd0, 4'h0, 1'b1, a);
    collect_read(exp, tag);
  endtask

  task automatic do_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] be);
    issue(1'b1, a, d, be, 1'b0, 14'd0);
  endtask

  // Counts rising edges after reset release until ready is seen high.
  task automatic wait_ready(output int n, output int n_valid, output int n_oob);
    n = 0; n_valid = 0; n_oob = 0;
    while (n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (bus.rd_valid) n_valid++;
      if (bus.oob_err) n_oob++;
      if (bus.ready) break;
    end
  endtask

  logic [31:0] stream_vals [4];

  initial begin
    int n, nv, no;
    bit exp_v;

    stream_vals[0] = 32'h0101_0101;
    stream_vals[1] = 32'h2222_0000;
    stream_vals[2] = 32'h0000_3333;
    stream_vals[3] = 32'h4444_4444;

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'd0, bus.ready}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    check_eq("rst_data", bus.rd_data, 32'd0);
    check_eq("rst_oob", {31'd0, bus.oob_err}, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(CLEAR));

    // power-up clear
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n, nv, no);
    check_eq("clr_latency", n, 32'd16000);
    check_eq("clr_no_valid", nv, 32'd0);
    check_eq("done_state", 32'(dbg_state), 32'(DONE));
    do_read(14'd15999, 32'h0000_0000, "rd_last");

    // byte-enable writes
    do_write(14'd100, 32'hDEAD_BEEF, 4'hF);
    do_write(14'd100, 32'h1122_3344, 4'b0101);
    do_read(14'd100, 32'hDE22_BE44, "rd_be");

    // write-first forwarding on same-cycle same-address access
    do_write(14'd7, 32'hAABB_CCDD, 4'hF);
    issue(1'b1, 14'd7, 32'hCAFE_F00D, 4'b0011, 1'b1, 14'd7);
    collect_read(32'hAABB_F00D, "rd_fwd");
    do_read(14'd7, 32'hAABB_F00D, "rd_after_fwd");

    // simultaneous access to different addresses
    issue(1'b1, 14'd8, 32'h0102_0304, 4'hF, 1'b1, 14'd100);
    collect_read(32'hDE22_BE44, "rd_indep");
    do_read(14'd8, 32'h0102_0304, "rd_addr8");
    check_eq("oob_clear", {31'd0, bus.oob_err}, 32'd0);

    // out-of-range accesses
    do_write(14'd16000, 32'h1234_5678, 4'hF);
    check_eq("oob_wr_flag", {31'd0, bus.oob_err}, 32'd1);
    do_read(14'd16000, 32'h0000_0000, "rd_oob");
    do_read(14'd15999, 32'h0000_0000, "rd_last_intact");
    do_read(14'd100, 32'hDE22_BE44, "rd_100_intact");
    check_eq("oob_sticky", {31'd0, bus.oob_err}, 32'd1);

    // back-to-back read stream with scoreboard
    for (int k = 0; k < 4; k++) do_write(14'(k), stream_vals[k], 4'hF);
    for (int j = 0; j < 4 + LAT + 1; j++) begin
      @(negedge clk);
      if (j < 4) begin
        bus.rd_en = 1'b1;
        bus.rd_addr = 14'(j);
        exp_q.push_back(stream_vals[j]);
      end else begin
        bus.rd_en = 1'b0;
      end
      @(posedge clk); #1;
      exp_v = (j >= LAT - 1) && (j - (LAT - 1) < 4);
      check_eq($sformatf("stream_valid_%0d", j), {31'd0, bus.rd_valid}, {31'd0, exp_v});
      if (exp_v && exp_q.size() > 0) begin
        check_eq($sformatf("stream_data_%0d", j), bus.rd_data, exp_q.pop_front());
      end
    end
    bus.rd_en = 1'b0;
    check_eq("stream_drained", exp_q.size(), 32'd0);

    // reset mid-clear, then requests during the restarted clear are ignored
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst2_ready", {31'd0, bus.ready}, 32'd0);
    check_eq("rst2_oob", {31'd0, bus.oob_err}, 32'd0);
    check_eq("rst2_data", bus.rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5000) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 14'd3; bus.wr_data = 32'h5555_5555; bus.wr_be = 4'hF;
    bus.rd_en = 1'b1; bus.rd_addr = 14'd16001;
    wait_ready(n, nv, no);
    idle_inputs();
    check_eq("reclr_latency", n, 32'd16000);
    check_eq("reclr_no_valid", nv, 32'd0);
    check_eq("reclr_no_oob", no, 32'd0);
    do_read(14'd3, 32'h0000_0000, "rd_clr_wr_ignored");
    do_read(14'd100, 32'h0000_0000, "rd_reclr_100");
    check_eq("oob_after_reclr", {31'd0, bus.oob_err}, 32'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
